// File: rtl/if_prefetch_pkg.sv
// Shared types, FSM encodings and address helper for the instruction prefetch unit.
package if_prefetch_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam logic [1:0] PF_IDLE   = 2'd0;
  localparam logic [1:0] PF_STREAM = 2'd1;
  localparam logic [1:0] PF_DRAIN  = 2'd2;

  function automatic inst_addr_t word_align(inst_addr_t addr);
    return addr & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Pipelined instruction bus: req/gnt request phase, in-order rvalid response phase.
interface if_prefetch_if;
  import if_prefetch_pkg::*;

  logic       bus_req_o;
  inst_addr_t bus_addr_o;
  logic       bus_gnt_i;
  logic       bus_rvalid_i;
  inst_t      bus_rdata_i;

  modport master (
    output bus_req_o, bus_addr_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_addr_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Small synchronous FIFO holding prefetched words; head word is visible combinationally.
module pf_fifo
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  inst_t                  wdata,
  output inst_t                  rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  inst_t         mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  // The credit scheme upstream must make overflow impossible.
  always_ff @(posedge clk) begin
    assert (!(push && count == (AW+1)'(DEPTH)));
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch unit: streams sequential words ahead of the PC and serves hits combinationally.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pc_ce_i,
  input  inst_addr_t    pc_i,
  output inst_t         inst_o,
  output logic          inst_valid_o,
  output logic          stall_req_o,
  if_prefetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    state;
  logic [1:0]    state_next;
  inst_addr_t    head_addr;
  inst_addr_t    fetch_addr;
  inst_addr_t    pc_word;
  logic [CW-1:0] count;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] drop;
  logic [CW:0]   credit;
  inst_t         head_word;
  logic          hit;
  logic          redirect;
  logic          granted;
  logic          push;

  assign pc_word    = word_align(pc_i);
  assign hit        = pc_ce_i && (count != '0) && (pc_word == head_addr);
  assign redirect   = pc_ce_i && (pc_word != head_addr);
  assign granted    = bus.bus_req_o && bus.bus_gnt_i;
  assign outst_next = outst + CW'(granted) - CW'(bus.bus_rvalid_i);
  // Responses owed to an abandoned stream, or arriving as we redirect, never enter the FIFO.
  assign push       = bus.bus_rvalid_i && (drop == '0) && !redirect;

  assign credit         = {1'b0, count} + {1'b0, outst};
  assign bus.bus_req_o  = (state == PF_STREAM) && (credit < (CW+1)'(DEPTH));
  assign bus.bus_addr_o = fetch_addr;

  assign inst_o       = hit ? head_word : '0;
  assign inst_valid_o = hit;
  assign stall_req_o  = rst && pc_ce_i && !hit;

  pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (hit),
    .wdata (bus.bus_rdata_i),
    .rdata (head_word),
    .count (count)
  );

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = (outst_next != '0) ? PF_DRAIN : PF_STREAM;
    end else begin
      case (state)
        PF_IDLE:   if (pc_ce_i) state_next = PF_STREAM;
        PF_STREAM: if (!pc_ce_i) state_next = PF_IDLE;
        PF_DRAIN:  if ((drop == CW'(1)) && bus.bus_rvalid_i)
                     state_next = pc_ce_i ? PF_STREAM : PF_IDLE;
        default:   state_next = PF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PF_IDLE;
      head_addr  <= '0;
      fetch_addr <= '0;
      outst      <= '0;
      drop       <= '0;
    end else begin
      state <= state_next;
      outst <= outst_next;
      if (redirect) begin
        head_addr  <= pc_word;
        fetch_addr <= pc_word;
        drop       <= outst_next;
      end else begin
        if (hit)     head_addr  <= head_addr + 32'd4;
        if (granted) fetch_addr <= fetch_addr + 32'd4;
        if (bus.bus_rvalid_i && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: random bus timing and core redirects against a transaction-level model.
module tb_if_prefetch;
  import if_prefetch_pkg::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       pc_ce;
  inst_addr_t pc;
  inst_t      inst;
  logic       inst_valid;
  logic       stall;

  if_prefetch_if bus_if ();

  if_prefetch #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_ce_i      (pc_ce),
    .pc_i         (pc),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .stall_req_o  (stall),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  int         delivered;
  int         gnt_pct;
  int         rv_pct;
  int         fifo_n;
  int         stale;
  inst_addr_t exp_head;
  inst_addr_t exp_fetch;
  inst_addr_t bus_q [$];
  inst_addr_t grant_log [$];
  logic       s_valid;
  logic       s_stall;
  logic       s_req;
  inst_t      s_inst;
  inst_addr_t s_addr;

  function automatic inst_t mem_word(inst_addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_head  = '0;
    exp_fetch = '0;
    fifo_n    = 0;
    stale     = 0;
    bus_q.delete();
    grant_log.delete();
  endtask

  task automatic drive_bus();
    bus_if.bus_gnt_i = ($urandom_range(99) < gnt_pct);
    if (bus_q.size() > 0 && $urandom_range(99) < rv_pct) begin
      bus_if.bus_rvalid_i = 1'b1;
      bus_if.bus_rdata_i  = mem_word(bus_q[0]);
    end else begin
      bus_if.bus_rvalid_i = 1'b0;
      bus_if.bus_rdata_i  = $urandom;
    end
  endtask

  // One clock: sample mid-cycle, compare with the model's prediction, advance the model.
  task automatic tick();
    logic       gr;
    logic       rv;
    logic       exp_valid;
    logic       redir;
    inst_addr_t pcw;
    @(negedge clk);
    s_valid = inst_valid;
    s_stall = stall;
    s_inst  = inst;
    s_req   = bus_if.bus_req_o;
    s_addr  = bus_if.bus_addr_o;
    gr  = s_req && bus_if.bus_gnt_i;
    rv  = bus_if.bus_rvalid_i;
    pcw = word_align(pc);
    exp_valid = pc_ce && (fifo_n > 0) && (pcw == exp_head);
    redir     = pc_ce && (pcw != exp_head);
    check("inst_valid", s_valid, exp_valid);
    check("stall_req", s_stall, pc_ce && !exp_valid);
    check("inst", s_inst, exp_valid ? mem_word(pcw) : 32'h0);
    if (stale > 0) check("req_during_drain", s_req, 1'b0);
    if (gr) begin
      check("req_addr", s_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
      grant_log.push_back(s_addr);
    end
    if (rv) void'(bus_q.pop_front());
    if (gr) bus_q.push_back(s_addr);
    if (redir) begin
      stale     = bus_q.size();
      fifo_n    = 0;
      exp_head  = pcw;
      exp_fetch = pcw;
      grant_log.delete();
    end else begin
      if (rv) begin
        if (stale > 0) stale--;
        else fifo_n++;
      end
      if (exp_valid) begin
        fifo_n--;
        exp_head = exp_head + 32'd4;
      end
    end
    check("credit_limit", 32'(fifo_n + bus_q.size() <= DEPTH), 32'd1);
    if (s_valid) delivered++;
    @(posedge clk);
    #1;
  endtask

  task automatic warm_run(int n);
    grant_log.delete();
    gnt_pct = 100;
    rv_pct  = 100;
    pc_ce   = 1'b1;
    pc      = '0;
    for (int c = 0; c < n; c++) begin
      drive_bus();
      tick();
      if (c == 0) check("warm_req_idle", s_req, 1'b0);
      if (c < 3) check("warm_stall", s_stall, 1'b1);
      else       check("warm_valid", s_valid, 1'b1);
      if (s_valid) pc = pc + 32'd4;
    end
    for (int i = 0; i < 4; i++)
      check("warm_addr", (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF, 32'(i * 4));
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_valid"}, inst_valid, 1'b0);
    check({tag, "_stall"}, stall, 1'b0);
    check({tag, "_req"}, bus_if.bus_req_o, 1'b0);
    check({tag, "_addr"}, bus_if.bus_addr_o, 32'h0);
  endtask

  initial begin
    int         n;
    int         d0;
    int         r;
    inst_addr_t tmp;
    inst_addr_t wrap_exp [4];
    total = 0;
    bad   = 0;
    delivered = 0;
    gnt_pct = 0;
    rv_pct  = 0;
    model_reset();
    rst   = 1'b0;
    pc_ce = 1'b1;
    pc    = '0;
    bus_if.bus_gnt_i    = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    bus_if.bus_rdata_i  = '0;

    $display("[TB] reset values");
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst = 1'b1;

    $display("[TB] cold start and steady stream");
    warm_run(24);

    $display("[TB] redirect with three requests outstanding");
    gnt_pct = 100;
    rv_pct  = 0;
    n = 0;
    while (bus_q.size() < 3 && n < 20) begin
      drive_bus();
      tick();
      if (s_valid) pc = pc + 32'd4;
      n++;
    end
    check("outst_before_redirect", bus_q.size(), 32'd3);
    pc = 32'h100;
    gnt_pct = 0;
    drive_bus();
    tick();
    gnt_pct = 100;
    rv_pct  = 100;
    n = 0;
    do begin
      drive_bus();
      tick();
      n++;
    end while (!s_valid && n < 12);
    check("redirect_latency", n, 32'd6);
    check("redirect_inst", s_inst, mem_word(32'h100));
    if (s_valid) pc = pc + 32'd4;
    for (int c = 0; c < 6; c++) begin
      drive_bus();
      tick();
      if (s_valid) pc = pc + 32'd4;
    end

    $display("[TB] grant held low");
    pc = 32'h200;
    gnt_pct = 0;
    n = 0;
    do begin
      drive_bus();
      tick();
      n++;
    end while (stale > 0 && n < 10);
    for (int c = 0; c < 5; c++) begin
      drive_bus();
      tick();
      check("hold_req", s_req, 1'b1);
      check("hold_addr", s_addr, 32'h200);
      check("hold_stall", s_stall, 1'b1);
    end
    gnt_pct = 100;
    n = 0;
    do begin
      drive_bus();
      tick();
      n++;
    end while (!s_valid && n < 8);
    check("hold_release_latency", n, 32'd3);
    if (s_valid) pc = pc + 32'd4;

    $display("[TB] address wrap");
    pc = 32'hFFFF_FFF8;
    for (int c = 0; c < 14; c++) begin
      drive_bus();
      tick();
      if (s_valid) pc = pc + 32'd4;
    end
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;
    for (int i = 0; i < 4; i++)
      check("wrap_addr", (i < grant_log.size()) ? grant_log[i] : 32'hDEAD_BEEF, wrap_exp[i]);

    $display("[TB] random bus timing and redirects");
    d0 = delivered;
    for (int c = 0; c < 500; c++) begin
      gnt_pct = $urandom_range(40, 100);
      rv_pct  = $urandom_range(40, 100);
      drive_bus();
      tick();
      r = $urandom_range(99);
      if (s_valid) pc = (word_align(pc) + 32'd4) | inst_addr_t'($urandom_range(3));
      if (r < 3) begin
        tmp = $urandom;
        pc  = (tmp & 32'h0000_3FFF) | 32'h0000_1000;
      end else if (r == 3) begin
        pc = 32'hFFFF_FFF4;
      end
      pc_ce = ($urandom_range(99) < 92);
    end
    check("random_progress", 32'(delivered - d0 > 40), 32'd1);

    $display("[TB] asynchronous reset with two requests outstanding");
    pc_ce   = 1'b1;
    pc      = 32'h300;
    gnt_pct = 100;
    rv_pct  = 100;
    n = 0;
    do begin
      drive_bus();
      tick();
      if (s_valid) pc = pc + 32'd4;
      n++;
    end while (!s_valid && n < 20);
    check("pre_reset_stream", s_valid, 1'b1);
    rv_pct = 0;
    n = 0;
    while (bus_q.size() < 2 && n < 10) begin
      drive_bus();
      tick();
      if (s_valid) pc = pc + 32'd4;
      n++;
    end
    check("outst_before_reset", bus_q.size(), 32'd2);
    #2 rst = 1'b0;
    bus_if.bus_gnt_i    = 1'b0;
    bus_if.bus_rvalid_i = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    warm_run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
